// File: rtl/fft16_vector_scheduler.sv
// Sequencer for one 16-point radix-4 FFT on a shared vector_size4 datapath.
// Issues 2 stages x 4 vectors, one in flight, with a WAIT timeout.
module fft16_vector_scheduler #(
    parameter int NUM_VEC   = 4,
    parameter int NUM_STAGE = 2,
    parameter int TIMEOUT   = 63
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fft_start,
    input  logic       inverse,
    input  logic       vec_done,
    output logic       vec_start,
    output logic [1:0] vec_control,
    output logic       stage,
    output logic [1:0] vec_idx,
    output logic [1:0] tw_addr,
    output logic       wr_en,
    output logic       busy,
    output logic       fft_done,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        DONE
    } state_t;

    localparam logic [1:0] LAST_VEC   = 2'(NUM_VEC - 1);
    localparam logic       LAST_STAGE = 1'(NUM_STAGE - 1);
    localparam logic [7:0] WAIT_MAX   = 8'(TIMEOUT - 1);

    state_t     state;
    logic       inv_q;
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            inv_q     <= 1'b0;
            wait_cnt  <= 8'd0;
            stage     <= 1'b0;
            vec_idx   <= 2'd0;
            vec_start <= 1'b0;
            wr_en     <= 1'b0;
            busy      <= 1'b0;
            fft_done  <= 1'b0;
            err       <= 1'b0;
        end else begin
            vec_start <= 1'b0;
            wr_en     <= 1'b0;
            fft_done  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (fft_start) begin
                        inv_q     <= inverse;
                        stage     <= 1'b0;
                        vec_idx   <= 2'd0;
                        err       <= 1'b0;
                        vec_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= 8'd0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (vec_done) begin
                        wr_en <= 1'b1;
                        state <= WRITE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        err      <= 1'b1;
                        fft_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WRITE: begin
                    if (vec_idx == LAST_VEC && stage == LAST_STAGE) begin
                        fft_done <= 1'b1;
                        state    <= DONE;
                    end else begin
                        if (vec_idx == LAST_VEC) begin
                            stage   <= stage + 1'b1;
                            vec_idx <= 2'd0;
                        end else begin
                            vec_idx <= vec_idx + 2'd1;
                        end
                        vec_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Control is only meaningful while a transform runs; park it at 0 in IDLE.
    assign vec_control = busy ? {inv_q, stage != LAST_STAGE} : 2'b00;
    assign tw_addr     = (stage == 1'b0) ? vec_idx : 2'd0;

endmodule

// File: tb/tb_fft16_vector_scheduler.sv
// Bench for fft16_vector_scheduler: timeline model of the transform
// plus directed scenarios with literal expectations.
module tb_fft16_vector_scheduler;

    localparam int TIMEOUT = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       fft_start = 1'b0;
    logic       inverse = 1'b0;
    logic       vec_done;
    logic       vec_start;
    logic [1:0] vec_control;
    logic       stage;
    logic [1:0] vec_idx;
    logic [1:0] tw_addr;
    logic       wr_en;
    logic       busy;
    logic       fft_done;
    logic       err;

    int checks = 0;
    int errors = 0;

    fft16_vector_scheduler #(
        .NUM_VEC(4),
        .NUM_STAGE(2),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .fft_start(fft_start),
        .inverse(inverse),
        .vec_done(vec_done),
        .vec_start(vec_start),
        .vec_control(vec_control),
        .stage(stage),
        .vec_idx(vec_idx),
        .tw_addr(tw_addr),
        .wr_en(wr_en),
        .busy(busy),
        .fft_done(fft_done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Datapath model: vec_done seen in WAIT cycle L+1 after the issue.
    int   dp_lat = 5;
    int   hang_k = -1;
    int   dp_cnt = 0;
    logic dp_done = 1'b0;
    logic spur = 1'b0;
    bit   spur_en = 1'b0;
    assign vec_done = dp_done | spur;

    always @(negedge clk) begin
        dp_done = 1'b0;
        if (dp_cnt > 0) begin
            dp_cnt = dp_cnt - 1;
            if (dp_cnt == 0) dp_done = 1'b1;
        end
        if (vec_start && int'({stage, vec_idx}) != hang_k)
            dp_cnt = dp_lat + 1;
        spur = spur_en && (vec_start || wr_en);
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    // Timeline model: a run is (start cycle, L, inverse, hang vector).
    int cyc = 0;
    bit run_active = 1'b0;
    int run_start, run_l, run_h;
    bit run_inv;

    function automatic int end_off();
        if (run_h >= 0) return run_h * (run_l + 3) + TIMEOUT + 1;
        return 8 * (run_l + 3);
    endfunction

    function automatic bit model_idle(input int t);
        return !run_active || (t - run_start) > end_off();
    endfunction

    always @(posedge clk) begin
        bit acc;
        acc = rst && fft_start && model_idle(cyc);
        cyc = cyc + 1;
        if (acc) begin
            run_active = 1'b1;
            run_start  = cyc;
            run_l      = dp_lat;
            run_h      = hang_k;
            run_inv    = inverse;
        end
    end

    always @(negedge rst) run_active = 1'b0;

    always @(negedge clk) begin
        int o, e, k, p, kl;
        bit eb, evs, ewr, edn, eer, cc;
        int es, ev, etw, ectl;
        bit [9:0] act, ex;
        eb = 0; evs = 0; ewr = 0; edn = 0; eer = 0;
        es = 0; ev = 0; cc = 1; ectl = 0;
        if (run_active) begin
            o  = cyc - run_start;
            e  = end_off();
            kl = (run_h >= 0) ? run_h : 7;
            if (o >= e) begin
                eer = (run_h >= 0);
                es  = kl / 4;
                ev  = kl % 4;
                if (o == e) begin
                    eb  = 1;
                    edn = 1;
                end else begin
                    cc = 0;
                end
            end else begin
                eb = 1;
                if (run_h >= 0 && o >= run_h * (run_l + 3)) begin
                    k = run_h;
                    p = o - k * (run_l + 3);
                end else begin
                    k   = o / (run_l + 3);
                    p   = o % (run_l + 3);
                    ewr = (p == run_l + 2);
                end
                evs = (p == 0);
                es  = k / 4;
                ev  = k % 4;
            end
            ectl = {run_inv, es == 0};
        end
        etw = (es == 0) ? ev : 0;
        act = {busy, vec_start, wr_en, fft_done, err, stage, vec_idx, tw_addr};
        ex  = {eb, evs, ewr, edn, eer, 1'(es), 2'(ev), 2'(etw)};
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL cycle %0d outputs got %b expected %b", cyc, act, ex);
        end
        if (cc) begin
            checks++;
            if (vec_control !== 2'(ectl)) begin
                errors++;
                $display("FAIL cycle %0d vec_control got %b expected %b",
                         cyc, vec_control, 2'(ectl));
            end
        end
    end

    // Run statistics gathered from the DUT for the literal checks.
    int n_start = 0, n_wr = 0, n_busy = 0;
    logic [1:0] rec_tw[16];
    logic [1:0] rec_ctl[16];

    always @(negedge clk) begin
        if (vec_start) begin
            if (n_start < 16) begin
                rec_tw[n_start]  = tw_addr;
                rec_ctl[n_start] = vec_control;
            end
            n_start++;
        end
        if (wr_en) n_wr++;
        if (busy) n_busy++;
    end

    task automatic clear_counts();
        n_start = 0;
        n_wr    = 0;
        n_busy  = 0;
    endtask

    task automatic pulse_start(input bit inv);
        @(negedge clk);
        inverse   = inv;
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!fft_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!fft_done) begin
            errors++;
            $display("FAIL %s fft_done timeout got 0 expected 1", name);
        end
    endtask

    task automatic chk_seq(input string name, input int base);
        logic [1:0] tw_exp[8]  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
        logic [1:0] ctl_exp[8] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};
        for (int i = 0; i < 8; i++) begin
            chk({name, "_tw"}, rec_tw[i], tw_exp[i]);
            chk({name, "_ctl"}, rec_ctl[i], ctl_exp[i] + base);
        end
    endtask

    task automatic chk_reset_outs(input string name);
        chk({name, "_outs"}, {vec_start, wr_en, fft_done, busy, err}, 0);
        chk({name, "_idx"}, {stage, vec_idx, tw_addr, vec_control}, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outs("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Forward, L=5
        dp_lat = 5;
        clear_counts();
        pulse_start(1'b0);
        chk("issue_first", {vec_start, busy}, 3);
        wait_done("fwd");
        @(negedge clk);
        chk("fwd_starts", n_start, 8);
        chk("fwd_writes", n_wr, 8);
        chk("fwd_busy", n_busy, 65);
        chk_seq("fwd", 0);

        // Inverse latched; live input toggled mid-run
        clear_counts();
        pulse_start(1'b1);
        repeat (20) @(negedge clk);
        inverse = 1'b0;
        wait_done("inv");
        @(negedge clk);
        chk("inv_writes", n_wr, 8);
        chk_seq("inv", 2);

        // Datapath hangs on stage 0 vector 2
        hang_k = 2;
        clear_counts();
        pulse_start(1'b0);
        wait_done("hang");
        chk("hang_err", err, 1);
        @(negedge clk);
        chk("hang_busy", n_busy, 2 * 8 + 1 + TIMEOUT + 1);
        repeat (10) @(negedge clk);
        chk("hang_starts", n_start, 3);
        chk("hang_writes", n_wr, 2);
        chk("hang_err_sticky", err, 1);
        hang_k = -1;
        clear_counts();
        pulse_start(1'b0);
        chk("err_cleared", err, 0);
        wait_done("after_hang");
        @(negedge clk);
        chk("after_hang_writes", n_wr, 8);

        // Held fft_start plus spurious vec_done in ISSUE/WRITE
        dp_lat  = 2;
        spur_en = 1'b1;
        clear_counts();
        @(negedge clk);
        fft_start = 1'b1;
        repeat (20) @(negedge clk);
        fft_start = 1'b0;
        wait_done("held");
        @(negedge clk);
        spur_en = 1'b0;
        chk("held_starts", n_start, 8);
        chk("held_writes", n_wr, 8);
        chk("held_busy", n_busy, 8 * 5 + 1);

        // Asynchronous reset in WAIT of stage 1 vector 1
        dp_lat = 5;
        clear_counts();
        pulse_start(1'b1);
        n = 0;
        while (!(vec_start && stage && vec_idx == 2'd1) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("rst_reach_s1v1", {stage, vec_idx}, 3'b101);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk_reset_outs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_counts();
        repeat (12) @(negedge clk);
        chk("late_done_writes", n_wr, 0);
        chk("late_done_starts", n_start, 0);
        clear_counts();
        pulse_start(1'b0);
        wait_done("post_rst");
        @(negedge clk);
        chk("post_rst_writes", n_wr, 8);

        // Back-to-back at minimum latency
        dp_lat = 1;
        clear_counts();
        pulse_start(1'b0);
        wait_done("b2b_1");
        @(negedge clk);
        fft_start = 1'b1;
        @(negedge clk);
        fft_start = 1'b0;
        chk("b2b_issue", {vec_start, busy, stage, vec_idx}, 5'b11000);
        wait_done("b2b_2");
        @(negedge clk);
        chk("b2b_writes", n_wr, 16);
        chk("b2b_busy", n_busy, 2 * (8 * 4 + 1));

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
